// File: rtl/fir_pkg.sv
// Shared constants and helpers for the streaming FIR filter.
// Sizing functions, reset coefficients and the saturation routine.
package fir_pkg;

  localparam int DEF_COEF0 = 4;
  localparam int DEF_COEF  = 0;

  function automatic int idx_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int acc_w(
    input int w,
    input int cw,
    input int taps
  );
    return w + cw + $clog2(taps);
  endfunction

  // Clamp a wide signed value into a w-bit signed range.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_sat.sv
// Combinational signed saturator from accumulator width to sample width.
// Also produces the even parity of the saturated result.
module fir_sat
  import fir_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 26
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [WIDTH-1:0] y_data,
  output logic                    y_parity
);

  logic signed [63:0] wide;

  always_comb begin
    wide     = saturate(64'(acc), WIDTH);
    y_data   = WIDTH'(wide);
    y_parity = ^y_data;
  end

endmodule

// File: rtl/fir_stream_filter.sv
// Streaming FIR filter with programmable taps, handshake and parity check.
// Two-stage pipeline: products, then sum + saturate.
module fir_stream_filter
  import fir_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int TAPS   = 4,
  parameter int COEF_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_wr,
  input  logic [idx_w(TAPS)-1:0]   coef_idx,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic signed [WIDTH-1:0]  x_data,
  input  logic                     x_valid,
  input  logic                     x_parity,
  output logic                     x_ready,
  output logic signed [WIDTH-1:0]  y_data,
  output logic                     y_valid,
  output logic                     y_parity,
  input  logic                     y_ready,
  output logic                     par_err
);

  localparam int IW    = idx_w(TAPS);
  localparam int PW    = WIDTH + COEF_W;
  localparam int ACC_W = acc_w(WIDTH, COEF_W, TAPS);

  logic signed [COEF_W-1:0] coef     [TAPS];
  logic signed [WIDTH-1:0]  tap      [TAPS];
  logic signed [WIDTH-1:0]  tap_nxt  [TAPS];
  logic signed [PW-1:0]     prod     [TAPS];
  logic signed [PW-1:0]     prod_nxt [TAPS];
  logic                     v1;
  logic                     stall;
  logic                     accept;
  logic                     x_ok;
  logic signed [ACC_W-1:0]  sum;
  logic signed [WIDTH-1:0]  sat_data;
  logic                     sat_par;

  assign stall   = y_valid & ~y_ready;
  assign x_ready = ~stall;
  assign accept  = x_valid & x_ready;
  assign x_ok    = (^x_data) == x_parity;

  // Products use the post-shift taps and the coefficients before any
  // same-edge write.
  always_comb begin
    tap_nxt[0] = x_ok ? x_data : '0;
    for (int i = 1; i < TAPS; i++) tap_nxt[i] = tap[i-1];
    for (int i = 0; i < TAPS; i++)
      prod_nxt[i] = PW'(coef[i]) * PW'(tap_nxt[i]);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++) sum = sum + ACC_W'(prod[i]);
  end

  fir_sat #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_sat (
    .acc      (sum),
    .y_data   (sat_data),
    .y_parity (sat_par)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++)
        coef[i] <= (i == 0) ? COEF_W'(DEF_COEF0) : COEF_W'(DEF_COEF);
    end else begin
      for (int i = 0; i < TAPS; i++)
        if (coef_wr && coef_idx == IW'(i)) coef[i] <= coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        tap[i]  <= '0;
        prod[i] <= '0;
      end
      v1       <= 1'b0;
      y_data   <= '0;
      y_valid  <= 1'b0;
      y_parity <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      if (accept && !x_ok) par_err <= 1'b1;
      if (!stall) begin
        if (accept) begin
          for (int i = 0; i < TAPS; i++) begin
            tap[i]  <= tap_nxt[i];
            prod[i] <= prod_nxt[i];
          end
        end
        v1      <= accept;
        y_valid <= v1;
        if (v1) begin
          y_data   <= sat_data;
          y_parity <= sat_par;
        end
      end
    end
  end

endmodule

// File: doc/fir_stream_filter.md
Name: fir_stream_filter

Overview:
- Parametrised streaming FIR filter; next generation of the fixed-gain filter block.
- Adds a configurable tap count and data width, runtime-programmable coefficients, a valid/ready handshake with back-pressure, saturation, and input parity checking.
- Sits on the sample datapath between a parity-protected source stream and a downstream consumer.

Parameters:
- WIDTH, 16: sample width; signed two's complement for both input and output.
- TAPS, 4: number of filter taps, ≥1.
- COEF_W, 8: coefficient width, signed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- coef_wr  in  1  coefficient write strobe.
- coef_idx  in  $clog2(TAPS) (min 1)  tap index for the coefficient write.
- coef_data  in  COEF_W  coefficient value.
- x_data  in  WIDTH  input sample.
- x_valid  in  1  input sample valid.
- x_parity  in  1  even parity of x_data.
- x_ready  out  1  block accepts the input sample.
- y_data  out  WIDTH  filtered, saturated output.
- y_valid  out  1  output valid.
- y_parity  out  1  even parity of y_data.
- y_ready  in  1  downstream accepts the output.
- par_err  out  1  sticky input parity-error flag.

Behaviour:
- Reset is synchronous, active-high, on the one clock, and may occur mid-operation. Reset clears:
  - the tap delay line (all zero);
  - the stage-1 and output valid bits;
  - y_data = 0, y_valid = 0, y_parity = 0, par_err = 0;
  - the coefficients to coef[0] = 4, coef[1..TAPS-1] = 0, so the reset filter is a ×4 gain.
- Anything in flight at reset is discarded; no output is produced for it.
- Handshake:
  - Input accept = x_valid & x_ready. Output transfer = y_valid & y_ready.
  - stall = y_valid & ~y_ready; x_ready = ~stall.
  - x_ready is a combinational function of registered state and y_ready only; no path from x_valid.
  - During a stall, all pipeline registers and the delay line hold.
- Pipeline, latency 2 cycles from accept to y_valid:
  - Accept edge: the delay line shifts (tap[0] ← x_data, tap[i] ← tap[i-1]). Stage 1 registers the TAPS products coef[i]*tap[i], computed on the post-shift taps, and sets v1.
  - Next unstalled edge: stage 2 sums the products, saturates, loads y_data, and sets y_valid = v1.
  - Full throughput: one sample per cycle while y_ready = 1.
  - y_valid drops after a transfer when no new result follows.
- Arithmetic:
  - Products are COEF_W+WIDTH bits signed.
  - Accumulator ACC_W = WIDTH+COEF_W+$clog2(TAPS), so the sum never wraps.
  - Saturation: results above 2^(WIDTH-1)-1 clamp to that value; results below -2^(WIDTH-1) clamp to that value.
  - y_parity = XOR-reduce of y_data, registered with y_data.
- Parity check:
  - On accept, if ^x_data != x_parity, the sample enters the delay line as 0 and par_err sets.
  - par_err stays set until reset.
- Coefficient writes:
  - coef_wr writes coef[coef_idx] ← coef_data at the edge, regardless of stall.
  - coef_idx ≥ TAPS is ignored.
  - A write and an accept in the same cycle: that sample's products use the old coefficients; the new value applies from the next accept.
  - Products already registered are not recomputed.
- Boundaries:
  - TAPS = 1 is a pure scaled pass-through.
  - x_valid without x_ready holds nothing inside the block; the source keeps x_data stable.

Decomposition:
- Package fir_pkg holds:
  - ACC_W and index-width helper functions;
  - the reset coefficient constants (DEF_COEF0 = 4, DEF_COEF = 0);
  - the saturate function.
- One sub-module, fir_sat: combinational ACC_W → WIDTH signed saturator with parity output. It is instantiated at stage 2.
- The delay line, products and handshake stay in fir_stream_filter.

Test Plan:
- Reset defaults: hold reset 2 cycles, then release with x_data = 3, x_valid = 1, x_parity = 0, y_ready = 1.
  - Same cycle: y_data = 0, y_valid = 0, y_parity = 0.
  - 2 cycles later: y_data = 12, y_valid = 1, y_parity = 0.
- Moving sum: write coef[0..3] = 1, then stream 1, 2, 3, 4, 5 with y_ready = 1. Outputs in order: 1, 3, 6, 10, 14, each 2 cycles after its accept, back-to-back.
- Back-pressure: stream 4 samples and drop y_ready for 3 cycles mid-stream.
  - x_ready = 0 while y_valid & ~y_ready.
  - y_data stays stable during the stall.
  - No sample is lost or duplicated; results match the unstalled run.
- Saturation: coef[0] = 127, x_data = 0x7FFF → y_data = 0x7FFF. x_data = 0x8000 → y_data = 0x8000.
- Parity error: x_data = 3, x_parity = 1 (wrong) → par_err = 1 from the next cycle and the sample contributes 0 (y_data = 0). par_err remains 1 until reset.
- Mid-operation reset and write collision:
  - Assert reset while v1 = 1 → y_valid never asserts for that sample, coefficients return to their defaults.
  - coef_wr together with an accept → that sample uses the old coefficient, the next sample uses the new one.
